// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data bus arbiter and its single-beat memory port.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned STRB_W   = 8;
    localparam int unsigned FETCH_W  = 32;
    localparam int unsigned STREAK_W = 4;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic               addr_ok;
        logic               data_ok;
        logic [FETCH_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        msize_t            size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } mem_resp_t;

endpackage

// File: rtl/mem_bus_arbiter_mem_req_mux.sv
// Maps the selected ibus/dbus request onto the memory request format and
// picks the 32-bit fetch word out of the 64-bit memory beat.
module mem_bus_arbiter_mem_req_mux
    import mem_bus_arbiter_pkg::*;
(
    input  ibus_req_t           i_ireq,
    input  dbus_req_t           i_dreq,
    input  logic                i_sel_d,
    input  logic                i_fetch_hi,
    input  logic [DATA_W-1:0]   i_mem_data,
    output mem_req_t            o_mreq_c,
    output logic [FETCH_W-1:0]  o_fetch_data_c
);

    always_comb begin
        o_mreq_c = '0;
        if (i_sel_d) begin
            o_mreq_c.valid    = i_dreq.valid;
            o_mreq_c.is_write = |i_dreq.strobe;
            o_mreq_c.size     = i_dreq.size;
            o_mreq_c.addr     = i_dreq.addr;
            o_mreq_c.strobe   = i_dreq.strobe;
            o_mreq_c.data     = i_dreq.data;
        end else begin
            // Fetches are always 4-byte reads with no write payload.
            o_mreq_c.valid = i_ireq.valid;
            o_mreq_c.size  = MSIZE4;
            o_mreq_c.addr  = i_ireq.addr;
        end
    end

    assign o_fetch_data_c = i_fetch_hi ? i_mem_data[DATA_W-1:FETCH_W] : i_mem_data[FETCH_W-1:0];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges the instruction-fetch and data buses onto one single-beat memory port,
// data first with a bounded streak so fetch cannot starve.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output mem_req_t   mreq,
    input  mem_resp_t  mresp
);

    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    owner_t              r_owner;
    owner_t              w_owner_next;
    mem_req_t            r_req;
    mem_req_t            w_req_next;
    logic [STREAK_W-1:0] r_d_streak;
    logic [STREAK_W-1:0] w_d_streak_next;

    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_ack_addr;
    logic                w_ack_data;
    mem_req_t            w_mux_req;
    logic [FETCH_W-1:0]  w_fetch_data;

    // Data wins a collision until it has taken MAX_STREAK grants in a row over a waiting fetch.
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (r_state == IDLE) begin
            if (dreq.valid && !(ireq.valid && (r_d_streak >= MAX_STREAK))) begin
                w_grant_d = 1'b1;
            end else if (ireq.valid) begin
                w_grant_i = 1'b1;
            end
        end
    end

    mem_bus_arbiter_mem_req_mux u_req_mux (
        .i_ireq         (ireq),
        .i_dreq         (dreq),
        .i_sel_d        (w_grant_d),
        .i_fetch_hi     (r_req.addr[2]),
        .i_mem_data     (mresp.data),
        .o_mreq_c       (w_mux_req),
        .o_fetch_data_c (w_fetch_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= OWNER_I;
            r_req      <= '0;
            r_d_streak <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_req      <= w_req_next;
            r_d_streak <= w_d_streak_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_req_next      = r_req;
        w_d_streak_next = r_d_streak;
        w_ack_addr      = 1'b0;
        w_ack_data      = 1'b0;
        mreq            = r_req;
        mreq.valid      = 1'b0;
        iresp           = '0;
        iresp.data      = w_fetch_data;
        dresp           = '0;
        dresp.data      = mresp.data;

        unique case (r_state)
            IDLE: begin
                if (w_grant_d || w_grant_i) begin
                    w_state_next = ISSUE;
                    w_owner_next = w_grant_d ? OWNER_D : OWNER_I;
                    w_req_next   = w_mux_req;
                    if (w_grant_d && ireq.valid) begin
                        if (r_d_streak < MAX_STREAK) begin
                            w_d_streak_next = r_d_streak + STREAK_W'(1);
                        end
                    end else begin
                        w_d_streak_next = '0;
                    end
                end
            end
            ISSUE: begin
                mreq.valid = 1'b1;
                w_ack_addr = mresp.addr_ok;
                // A data_ok riding on the same beat as addr_ok completes the transaction.
                w_ack_data = mresp.addr_ok & mresp.data_ok;
                if (mresp.addr_ok) begin
                    w_state_next = mresp.data_ok ? IDLE : WAIT;
                end
            end
            WAIT: begin
                w_ack_data = mresp.data_ok;
                if (mresp.data_ok) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (r_owner == OWNER_D) begin
            dresp.addr_ok = w_ack_addr;
            dresp.data_ok = w_ack_data;
        end else begin
            iresp.addr_ok = w_ack_addr;
            iresp.data_ok = w_ack_data;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requests, a latency-programmable
// memory model, and a monitor checking issue order and response routing.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int unsigned MAXS = 4;

    typedef struct packed {
        logic        is_d;
        logic [63:0] data;
    } exp_rsp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    mem_req_t   mreq;
    mem_resp_t  mresp;

    mem_bus_arbiter #(.MAX_D_STREAK(MAXS)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .mreq  (mreq),
        .mresp (mresp)
    );

    always #5 clk = ~clk;

    mem_req_t  exp_req_q[$];
    exp_rsp_t  exp_rsp_q[$];
    ibus_req_t i_stim_q[$];
    dbus_req_t d_stim_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          addr_lat = 1;
    int          data_lat = 1;
    logic [63:0] mem_rdata = 64'h0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue_fetch(input logic [63:0] a, input logic [31:0] word);
        ibus_req_t r;
        mem_req_t  m;
        exp_rsp_t  e;
        r.valid = 1'b1;
        r.addr  = a;
        m = '0;
        m.valid = 1'b1;
        m.size  = MSIZE4;
        m.addr  = a;
        e.is_d  = 1'b0;
        e.data  = 64'(word);
        exp_req_q.push_back(m);
        exp_rsp_q.push_back(e);
        i_stim_q.push_back(r);
    endtask

    task automatic issue_data(input logic [63:0] a, input msize_t sz, input logic [7:0] strb,
                              input logic [63:0] wdata, input logic is_wr);
        dbus_req_t r;
        mem_req_t  m;
        exp_rsp_t  e;
        r.valid  = 1'b1;
        r.addr   = a;
        r.size   = sz;
        r.strobe = strb;
        r.data   = wdata;
        m.valid    = 1'b1;
        m.is_write = is_wr;
        m.size     = sz;
        m.addr     = a;
        m.strobe   = strb;
        m.data     = wdata;
        e.is_d = 1'b1;
        e.data = mem_rdata;
        exp_req_q.push_back(m);
        exp_rsp_q.push_back(e);
        d_stim_q.push_back(r);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_rsp_q.size() != 0 || exp_req_q.size() != 0 || i_stim_q.size() != 0 ||
                d_stim_q.size() != 0 || ireq.valid || dreq.valid) && n < 400) begin
            @(negedge clk); #2;
            n++;
        end
        check(name, 160'(exp_rsp_q.size() + exp_req_q.size() + i_stim_q.size() + d_stim_q.size()), 160'(0));
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_iresp"}, 160'(iresp), 160'(0));
        check({name, "_dresp"}, 160'(dresp), 160'(0));
        check({name, "_mreq"}, 160'(mreq), 160'(0));
        check({name, "_streak"}, 160'(dut.r_d_streak), 160'(0));
    endtask

    // Memory model: addr_ok addr_lat cycles into ISSUE, data_ok data_lat cycles after addr_ok.
    int       mphase = 0;
    int       mcnt = 0;
    mem_req_t mcap = '0;
    initial begin : memory_model
        mresp = '0;
        forever begin
            @(posedge clk); #1;
            mresp = '0;
            if (reset) begin
                mphase = 0;
            end else begin
                if (mphase == 0 && mreq.valid) begin
                    mphase = 1;
                    mcnt   = addr_lat;
                    mcap   = mreq;
                end else if (mphase == 1) begin
                    check("mreq_stable", 160'(mreq), 160'(mcap));
                end
                if (mphase == 1) begin
                    if (mcnt == 0) begin
                        mresp.addr_ok = 1'b1;
                        if (data_lat == 0) begin
                            mresp.data_ok = 1'b1;
                            mresp.data    = mem_rdata;
                            mphase = 0;
                        end else begin
                            mphase = 2;
                            mcnt   = data_lat;
                        end
                    end else begin
                        mcnt--;
                    end
                end else if (mphase == 2) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        mresp.data_ok = 1'b1;
                        mresp.data    = mem_rdata;
                        mphase = 0;
                    end
                end
            end
        end
    end

    initial begin : ibus_agent
        ireq = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ireq = '0;
            end else if (ireq.valid && iresp.data_ok) begin
                if (i_stim_q.size() != 0) ireq = i_stim_q.pop_front();
                else ireq = '0;
            end else if (!ireq.valid && i_stim_q.size() != 0) begin
                ireq = i_stim_q.pop_front();
            end
        end
    end

    initial begin : dbus_agent
        dreq = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                dreq = '0;
            end else if (dreq.valid && dresp.data_ok) begin
                if (d_stim_q.size() != 0) dreq = d_stim_q.pop_front();
                else dreq = '0;
            end else if (!dreq.valid && d_stim_q.size() != 0) begin
                dreq = d_stim_q.pop_front();
            end
        end
    end

    logic last_mvalid = 1'b0;
    logic prev_dok = 1'b0;
    initial begin : monitor
        exp_rsp_t e;
        mem_req_t m;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_mvalid = 1'b0;
                prev_dok    = 1'b0;
            end else begin
                if (prev_dok) begin
                    check("idle_after_dok",
                          160'({mreq.valid, iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok}),
                          160'(0));
                end
                if (mreq.valid && !last_mvalid) begin
                    if (exp_req_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_issue: got addr %h expected no issue", mreq.addr);
                    end else begin
                        m = exp_req_q.pop_front();
                        check("mreq_issue", 160'(mreq), 160'(m));
                    end
                end
                last_mvalid = mreq.valid;
                if (iresp.addr_ok || dresp.addr_ok) begin
                    check("addr_ok_route", 160'({mreq.valid, iresp.addr_ok & dresp.addr_ok}), 160'(2'b10));
                end
                if (iresp.data_ok || dresp.data_ok) begin
                    if (exp_rsp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_data_ok: got i=%0b d=%0b expected none",
                                 iresp.data_ok, dresp.data_ok);
                    end else begin
                        e = exp_rsp_q.pop_front();
                        check("rsp_owner", 160'({iresp.data_ok, dresp.data_ok}), 160'({~e.is_d, e.is_d}));
                        if (e.is_d) begin
                            check("dresp_data", 160'(dresp.data), 160'(e.data));
                            check("iresp_quiet", 160'(iresp.addr_ok), 160'(0));
                        end else begin
                            check("iresp_data", 160'(iresp.data), 160'(e.data));
                            check("dresp_quiet", 160'(dresp.addr_ok), 160'(0));
                        end
                    end
                end
                prev_dok = iresp.data_ok | dresp.data_ok;
            end
        end
    end

    initial begin : stimulus
        int n;
        repeat (3) @(negedge clk);
        #2;
        check_outputs_zero("reset_state");
        reset = 1'b0;
        @(negedge clk); #2;

        // Single fetch, upper word of the beat.
        addr_lat = 1; data_lat = 1;
        mem_rdata = 64'h1111_2222_3333_4444;
        issue_fetch(64'h8000_0004, 32'h1111_2222);
        wait_drain("single_fetch_drain");

        // Collision: store wins, fetch follows.
        issue_data(64'h8000_1000, MSIZE8, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b1);
        issue_fetch(64'h8000_0000, 32'h3333_4444);
        wait_drain("collision_drain");

        // Starvation bound: D,D,D,D,I,D,D.
        mem_rdata = 64'hA5A5_0000_5A5A_FFFF;
        for (int k = 0; k < 4; k++) begin
            issue_data(64'h8000_3000 + 64'(8 * k), MSIZE8, 8'h00, 64'h0, 1'b0);
        end
        issue_fetch(64'h8000_0104, 32'hA5A5_0000);
        issue_data(64'h8000_3020, MSIZE8, 8'h00, 64'h0, 1'b0);
        issue_data(64'h8000_3028, MSIZE8, 8'h00, 64'h0, 1'b0);
        wait_drain("starvation_drain");

        // Slow memory.
        addr_lat = 3; data_lat = 5;
        mem_rdata = 64'h0123_4567_89AB_CDEF;
        issue_data(64'h8000_4010, MSIZE4, 8'h0F, 64'h0000_0000_CAFE_F00D, 1'b1);
        wait_drain("slow_mem_drain");

        // Combined addr_ok+data_ok.
        addr_lat = 0; data_lat = 0;
        mem_rdata = 64'hFEED_FACE_0BAD_CAFE;
        issue_data(64'h8000_5008, MSIZE8, 8'h00, 64'h0, 1'b0);
        issue_fetch(64'h8000_5000, 32'h0BAD_CAFE);
        wait_drain("combined_drain");

        // Reset during WAIT.
        addr_lat = 0; data_lat = 6;
        issue_data(64'h8000_6000, MSIZE8, 8'h00, 64'h0, 1'b0);
        issue_fetch(64'h8000_6000, 32'h0BAD_CAFE);
        n = 0;
        while (!dresp.addr_ok && n < 20) begin
            @(negedge clk); #2;
            n++;
        end
        check("reset_reach_addr_ok", 160'(dresp.addr_ok), 160'(1));
        @(negedge clk); #2;
        check("streak_before_reset", 160'(dut.r_d_streak), 160'(1));
        reset = 1'b1;
        @(negedge clk); #2;
        check_outputs_zero("reset_mid_wait");
        exp_req_q.delete();
        exp_rsp_q.delete();
        i_stim_q.delete();
        d_stim_q.delete();
        reset = 1'b0;
        @(negedge clk); #2;

        addr_lat = 1; data_lat = 1;
        mem_rdata = 64'h7777_8888_9999_AAAA;
        issue_fetch(64'h8000_7004, 32'h7777_8888);
        wait_drain("post_reset_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
